// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage divider and its controller hookup.
package ex_div_pkg;

  localparam int unsigned DataWidth = 32;

  // Controller stall vector width and the "frozen" bit value.
  localparam int unsigned StallBus = 6;
  localparam logic        Stop     = 1'b1;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Two's-complement negate.
  function automatic logic [DataWidth-1:0] neg32(input logic [DataWidth-1:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX-stage <-> divider signal bundle; master is the pipeline side, slave the divider.
interface ex_div_if;

  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        ex_hold_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i, ex_hold_i,
    input  quotient_o, remainder_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i, ex_hold_i,
    output quotient_o, remainder_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/ex_div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the
// upper 33 bits of the shift register and shift in the resulting quotient bit.
module ex_div_step (
  input  logic [64:0] sr_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] sr_o,
  output logic        q_bit_o
);

  logic [33:0] diff;
  logic        unused_diff;

  // Trial subtract; a clear sign bit means the subtraction is committed.
  always_comb begin
    diff    = {1'b0, sr_i[64:32]} - {2'b00, divisor_i};
    q_bit_o = ~diff[33];
    if (q_bit_o) begin
      // Committed difference is below the divisor, so it fits in 32 bits.
      sr_o = {diff[31:0], sr_i[31:0], 1'b1};
    end else begin
      sr_o = {sr_i[63:0], 1'b0};
    end
  end

  assign unused_diff = diff[32];

endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32-bit DIV/DIVU for the EX stage. Quotient goes to LO, remainder
// to HI; a stall request freezes PC..EX while a division is in flight.
module ex_div
  import ex_div_pkg::*;
(
  input logic     clk,
  input logic     rst,
  ex_div_if.slave bus
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [64:0] sr_q;
  logic [31:0] divisor_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        ready_q;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [64:0] step_sr;
  logic        step_q_bit;
  logic        unused_step;

  // Operand magnitudes, only meaningful in the cycle the FSM leaves IDLE.
  always_comb begin
    dividend_abs = bus.dividend_i;
    divisor_abs  = bus.divisor_i;
    if (bus.signed_i && bus.dividend_i[31]) dividend_abs = neg32(bus.dividend_i);
    if (bus.signed_i && bus.divisor_i[31])  divisor_abs  = neg32(bus.divisor_i);
  end

  ex_div_step u_step (
    .sr_i      (sr_q),
    .divisor_i (divisor_q),
    .sr_o      (step_sr),
    .q_bit_o   (step_q_bit)
  );

  // Division FSM; annul wins over start and hold in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DivFree;
      cnt_q       <= 6'd0;
      sr_q        <= 65'd0;
      divisor_q   <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      ready_q     <= DivResultNotReady;
    end else if (bus.annul_i) begin
      state_q <= DivFree;
      ready_q <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (bus.start_i) begin
            state_q   <= (bus.divisor_i == 32'd0) ? DivByZero : DivOn;
            cnt_q     <= 6'd0;
            sr_q      <= {32'd0, dividend_abs, 1'b0};
            divisor_q <= divisor_abs;
            neg_quo_q <= bus.signed_i & (bus.dividend_i[31] ^ bus.divisor_i[31]);
            neg_rem_q <= bus.signed_i & bus.dividend_i[31];
          end
        end
        DivByZero: begin
          state_q     <= DivEnd;
          quotient_q  <= 32'd0;
          remainder_q <= 32'd0;
          ready_q     <= DivResultReady;
        end
        DivOn: begin
          sr_q  <= step_sr;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            // Final step: results are registered so they are valid throughout END.
            state_q     <= DivEnd;
            quotient_q  <= neg_quo_q ? neg32(step_sr[31:0]) : step_sr[31:0];
            remainder_q <= neg_rem_q ? neg32(step_sr[64:33]) : step_sr[64:33];
            ready_q     <= DivResultReady;
          end
        end
        DivEnd: begin
          // A held EX keeps the same DIV in place; staying here stops a restart.
          if (!bus.ex_hold_i) begin
            state_q <= DivFree;
            ready_q <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign bus.quotient_o  = quotient_q;
  assign bus.remainder_o = remainder_q;
  assign bus.ready_o     = ready_q;
  assign bus.stallreq_o  = bus.start_i & ~bus.annul_i & (state_q != DivEnd);

  assign unused_step = step_sr[32] ^ step_q_bit;

endmodule
